// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
//   ID/EX pipeline register plus EX-stage operand selection for the
//   five-stage MIPS core. It captures decoded ID fields and resolves
//   EX/MEM and MEM/WB forwarding into the ALU operands. It also detects
//   load-use hazards and inserts a bubble for them.
//
// Ports
//   i_clk, i_reset         : clock (rising edge), synchronous active-high reset
//   i_stall_in             : hold the ID/EX register (back-end freeze)
//   i_flush                : squash the ID instruction (bubble)
//   i_id_*                 : decoded ID-stage fields and control bits
//   i_exmem_*, i_memwb_*   : forwarding sources (write enable, rd, value)
//   o_alu_in1, o_alu_in2   : forwarded / muxed ALU operands
//   o_alu_ctl, o_alu_sign  : ALU opcode and signed-compare select
//   o_ex_store_data        : forwarded rt value for stores
//   o_ex_rd, o_ex_*        : registered destination and control bits
//   o_load_use_stall       : combinational hold request for PC and IF/ID
// ---------------------------------------------------------------------------
module ex_operand_stage (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall_in,
  input  logic        i_flush,
  input  logic        i_id_valid,
  input  logic [4:0]  i_id_rs_addr,
  input  logic [4:0]  i_id_rt_addr,
  input  logic [4:0]  i_id_rd_addr,
  input  logic [31:0] i_id_rs_data,
  input  logic [31:0] i_id_rt_data,
  input  logic [31:0] i_id_imm,
  input  logic [4:0]  i_id_shamt,
  input  logic [4:0]  i_id_alu_ctl,
  input  logic        i_id_sign,
  input  logic        i_id_alusrc1,
  input  logic        i_id_alusrc2,
  input  logic        i_id_reg_write,
  input  logic        i_id_mem_read,
  input  logic        i_id_mem_write,
  input  logic        i_exmem_reg_write,
  input  logic [4:0]  i_exmem_rd,
  input  logic [31:0] i_exmem_result,
  input  logic        i_memwb_reg_write,
  input  logic [4:0]  i_memwb_rd,
  input  logic [31:0] i_memwb_data,
  output logic [31:0] o_alu_in1,
  output logic [31:0] o_alu_in2,
  output logic [4:0]  o_alu_ctl,
  output logic        o_alu_sign,
  output logic [31:0] o_ex_store_data,
  output logic [4:0]  o_ex_rd,
  output logic        o_ex_reg_write,
  output logic        o_ex_mem_read,
  output logic        o_ex_mem_write,
  output logic        o_ex_valid,
  output logic        o_load_use_stall
);

  logic        r_valid;
  logic [4:0]  r_rs_addr;
  logic [4:0]  r_rt_addr;
  logic [4:0]  r_rd;
  logic [31:0] r_rs_data;
  logic [31:0] r_rt_data;
  logic [31:0] r_imm;
  logic [4:0]  r_shamt;
  logic [4:0]  r_alu_ctl;
  logic        r_sign;
  logic        r_alusrc1;
  logic        r_alusrc2;
  logic        r_reg_write;
  logic        r_mem_read;
  logic        r_mem_write;

  logic        w_load_use;
  logic        w_bubble;
  logic [31:0] w_fwd_rs;
  logic [31:0] w_fwd_rt;

  // Forward priority: EX/MEM (youngest) over MEM/WB over the register-file
  // read data. Register $0 is never forwarded.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  addr,
    input logic [31:0] reg_data,
    input logic        exmem_we,
    input logic [4:0]  exmem_rd,
    input logic [31:0] exmem_val,
    input logic        memwb_we,
    input logic [4:0]  memwb_rd,
    input logic [31:0] memwb_val
  );
    logic [31:0] sel;
    if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == addr)) begin
      sel = exmem_val;
    end else if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == addr)) begin
      sel = memwb_val;
    end else begin
      sel = reg_data;
    end
    return sel;
  endfunction

  // Load-use hazard: the load in EX writes a register the ID instruction
  // reads. Suppressed during a hold because nothing advances then.
  always_comb begin
    w_load_use = 1'b0;
    if (!i_stall_in && r_valid && r_mem_read && (r_rd != 5'd0) && i_id_valid &&
        ((r_rd == i_id_rs_addr) || (r_rd == i_id_rt_addr))) begin
      w_load_use = 1'b1;
    end else begin
      w_load_use = 1'b0;
    end
  end

  assign w_bubble = i_flush | w_load_use;

  // ID/EX register: reset and bubble both clear every field; a hold
  // leaves the register untouched.
  always_ff @(posedge i_clk) begin
    if (i_reset || (!i_stall_in && w_bubble)) begin
      r_valid     <= 1'b0;
      r_rs_addr   <= 5'd0;
      r_rt_addr   <= 5'd0;
      r_rd        <= 5'd0;
      r_rs_data   <= 32'd0;
      r_rt_data   <= 32'd0;
      r_imm       <= 32'd0;
      r_shamt     <= 5'd0;
      r_alu_ctl   <= 5'b00000;
      r_sign      <= 1'b0;
      r_alusrc1   <= 1'b0;
      r_alusrc2   <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (!i_stall_in) begin
      r_valid     <= i_id_valid;
      r_rs_addr   <= i_id_rs_addr;
      r_rt_addr   <= i_id_rt_addr;
      r_rd        <= i_id_rd_addr;
      r_rs_data   <= i_id_rs_data;
      r_rt_data   <= i_id_rt_data;
      r_imm       <= i_id_imm;
      r_shamt     <= i_id_shamt;
      r_alu_ctl   <= i_id_alu_ctl;
      r_sign      <= i_id_sign;
      r_alusrc1   <= i_id_alusrc1;
      r_alusrc2   <= i_id_alusrc2;
      r_reg_write <= i_id_reg_write;
      r_mem_read  <= i_id_mem_read;
      r_mem_write <= i_id_mem_write;
    end
  end

  // Forwarded operands and ALU input muxes. Shifts take the amount from
  // in1[4:0], so shamt is zero-extended into operand 1.
  always_comb begin
    w_fwd_rs = fwd_sel(r_rs_addr, r_rs_data, i_exmem_reg_write, i_exmem_rd,
                       i_exmem_result, i_memwb_reg_write, i_memwb_rd, i_memwb_data);
    w_fwd_rt = fwd_sel(r_rt_addr, r_rt_data, i_exmem_reg_write, i_exmem_rd,
                       i_exmem_result, i_memwb_reg_write, i_memwb_rd, i_memwb_data);
    if (r_alusrc1) begin
      o_alu_in1 = {27'd0, r_shamt};
    end else begin
      o_alu_in1 = w_fwd_rs;
    end
    if (r_alusrc2) begin
      o_alu_in2 = r_imm;
    end else begin
      o_alu_in2 = w_fwd_rt;
    end
  end

  assign o_ex_store_data  = w_fwd_rt;
  assign o_alu_ctl        = r_alu_ctl;
  assign o_alu_sign       = r_sign;
  assign o_ex_rd          = r_rd;
  assign o_ex_reg_write   = r_reg_write;
  assign o_ex_mem_read    = r_mem_read;
  assign o_ex_mem_write   = r_mem_write;
  assign o_ex_valid       = r_valid;
  assign o_load_use_stall = w_load_use;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset, stall_in, flush;
  logic        id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt, id_alu_ctl;
  logic        id_sign, id_alusrc1, id_alusrc2;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic [31:0] alu_in1, alu_in2, ex_store_data;
  logic [4:0]  alu_ctl, ex_rd;
  logic        alu_sign, ex_reg_write, ex_mem_read, ex_mem_write, ex_valid;
  logic        load_use_stall;

  int n_checks = 0;
  int n_errors = 0;
  logic [110:0] sb_q[$];

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .i_clk(clk), .i_reset(reset), .i_stall_in(stall_in), .i_flush(flush),
    .i_id_valid(id_valid), .i_id_rs_addr(id_rs_addr), .i_id_rt_addr(id_rt_addr),
    .i_id_rd_addr(id_rd_addr), .i_id_rs_data(id_rs_data), .i_id_rt_data(id_rt_data),
    .i_id_imm(id_imm), .i_id_shamt(id_shamt), .i_id_alu_ctl(id_alu_ctl),
    .i_id_sign(id_sign), .i_id_alusrc1(id_alusrc1), .i_id_alusrc2(id_alusrc2),
    .i_id_reg_write(id_reg_write), .i_id_mem_read(id_mem_read),
    .i_id_mem_write(id_mem_write), .i_exmem_reg_write(exmem_reg_write),
    .i_exmem_rd(exmem_rd), .i_exmem_result(exmem_result),
    .i_memwb_reg_write(memwb_reg_write), .i_memwb_rd(memwb_rd),
    .i_memwb_data(memwb_data), .o_alu_in1(alu_in1), .o_alu_in2(alu_in2),
    .o_alu_ctl(alu_ctl), .o_alu_sign(alu_sign), .o_ex_store_data(ex_store_data),
    .o_ex_rd(ex_rd), .o_ex_reg_write(ex_reg_write), .o_ex_mem_read(ex_mem_read),
    .o_ex_mem_write(ex_mem_write), .o_ex_valid(ex_valid),
    .o_load_use_stall(load_use_stall)
  );

  function automatic logic [110:0] mk(
    input logic [31:0] in1, input logic [31:0] in2, input logic [4:0] ctl,
    input logic sgn, input logic [31:0] st, input logic [4:0] rd,
    input logic rw, input logic mr, input logic mw, input logic v);
    return {in1, in2, ctl, sgn, st, rd, rw, mr, mw, v};
  endfunction

  task automatic push(input logic [110:0] e);
    sb_q.push_back(e);
  endtask

  task automatic check(input string tag);
    logic [110:0] exp_v;
    logic [110:0] obs_v;
    exp_v = sb_q.pop_front();
    obs_v = {alu_in1, alu_in2, alu_ctl, alu_sign, ex_store_data, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_valid};
    n_checks++;
    assert (obs_v === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
    end
  endtask

  task automatic chk_lu(input string tag, input logic exp_v);
    n_checks++;
    assert (load_use_stall === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, load_use_stall, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(
    input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
    input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
    input logic [4:0] sh, input logic [4:0] ctl, input logic sgn,
    input logic s1, input logic s2, input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_shamt = sh;
    id_alu_ctl = ctl; id_sign = sgn; id_alusrc1 = s1; id_alusrc2 = s2;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic set_fwd(
    input logic ew, input logic [4:0] erd, input logic [31:0] eres,
    input logic mw, input logic [4:0] mrd, input logic [31:0] mdat);
    exmem_reg_write = ew; exmem_rd = erd; exmem_result = eres;
    memwb_reg_write = mw; memwb_rd = mrd; memwb_data = mdat;
  endtask

  // Reusable instructions
  task automatic id_lw();   // lw $8, 4($4)
    set_id(1'b1, 5'd4, 5'd8, 5'd8, 32'h1000, 32'h0, 32'h4, 5'd0, 5'd1, 1'b0,
           1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask
  task automatic id_dep();  // add $12, $1, $8
    set_id(1'b1, 5'd1, 5'd8, 5'd12, 32'h5, 32'hBAD, 32'h0, 5'd0, 5'd1, 1'b0,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic id_x();
    set_id(1'b1, 5'd1, 5'd2, 5'd13, 32'h5, 32'h6, 32'h0, 5'd0, 5'd3, 1'b0,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic id_y();
    set_id(1'b1, 5'd7, 5'd7, 5'd14, 32'h70, 32'h71, 32'h0, 5'd0, 5'd4, 1'b0,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [110:0] zero_e, lw_e, x_e;
    zero_e = mk(32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    lw_e   = mk(32'h1000, 32'h4, 5'd1, 1'b0, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    x_e    = mk(32'h5, 32'h6, 5'd3, 1'b0, 32'h6, 5'd13, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset with random ID and forward inputs
    reset = 1'b1; stall_in = 1'b0; flush = 1'b0;
    set_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
           $urandom, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'b1, 1'b1, 1'($urandom));
    set_fwd(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
    step(); step();
    push(zero_e); check("reset_outputs");
    chk_lu("reset_lu", 1'b0);

    // First load after release
    reset = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h10, 5'd0, 5'd2, 1'b1,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    push(mk(32'h100, 32'h200, 5'd2, 1'b1, 32'h200, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1));
    check("first_load");

    // Forward priority on rs, then rt
    set_id(1'b1, 5'd5, 5'd6, 5'd7, 32'h33, 32'h44, 32'h0, 5'd0, 5'd0, 1'b0,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    set_fwd(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
    step();
    push(mk(32'h11, 32'h44, 5'd0, 1'b0, 32'h44, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1));
    check("fwd_exmem");
    set_fwd(1'b0, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22); #1;
    push(mk(32'h22, 32'h44, 5'd0, 1'b0, 32'h44, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1));
    check("fwd_memwb");
    set_fwd(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22); #1;
    push(mk(32'h33, 32'h44, 5'd0, 1'b0, 32'h44, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1));
    check("fwd_r0_none");
    set_fwd(1'b1, 5'd6, 32'h11, 1'b0, 5'd0, 32'h0); #1;
    push(mk(32'h33, 32'h11, 5'd0, 1'b0, 32'h11, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1));
    check("fwd_rt_exmem");

    // sll: shamt drives operand 1
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_id(1'b1, 5'd0, 5'd9, 5'd10, 32'hDEAD, 32'h1, 32'h0, 5'd4, 5'd8, 1'b0,
           1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    push(mk(32'h4, 32'h1, 5'd8, 1'b0, 32'h1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1));
    check("sll_shamt");

    // addi: immediate on operand 2, store data stays rt
    set_id(1'b1, 5'd3, 5'd11, 5'd11, 32'h50, 32'h77, 32'hFFFFFFF0, 5'd0, 5'd1, 1'b1,
           1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    push(mk(32'h50, 32'hFFFFFFF0, 5'd1, 1'b1, 32'h77, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1));
    check("addi_imm");

    // Load-use: stall, bubble, then MEM/WB forward
    id_lw(); step();
    push(lw_e); check("lw_load");
    id_dep(); #1;
    chk_lu("lu_detect", 1'b1);
    step();
    push(zero_e); check("lu_bubble");
    chk_lu("lu_after_bubble", 1'b0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'hCAFEBABE);
    step();
    push(mk(32'h5, 32'hCAFEBABE, 5'd1, 1'b0, 32'hCAFEBABE, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1));
    check("lu_memwb_fwd");

    // Load to $0 never stalls
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_id(1'b1, 5'd4, 5'd0, 5'd0, 32'h1000, 32'h0, 32'h4, 5'd0, 5'd1, 1'b0,
           1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    push(mk(32'h1000, 32'h4, 5'd1, 1'b0, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1));
    check("lw_r0_load");
    set_id(1'b1, 5'd1, 5'd0, 5'd12, 32'h5, 32'h0, 32'h0, 5'd0, 5'd1, 1'b0,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk_lu("lu_r0_none", 1'b0);

    // Flush vs stall
    id_x(); step();
    push(x_e); check("x_load");
    id_y(); flush = 1'b1; step();
    push(zero_e); check("flush_bubble");
    flush = 1'b0; id_x(); step();
    push(x_e); check("x_reload");
    stall_in = 1'b1; flush = 1'b1; id_y(); step();
    push(x_e); check("stall_over_flush");
    stall_in = 1'b0; step();
    push(zero_e); check("flush_on_release");
    flush = 1'b0;

    // Flush together with load-use: one bubble, stall still driven
    id_lw(); step();
    push(lw_e); check("lw_load2");
    id_dep(); flush = 1'b1; #1;
    chk_lu("flush_lu_driven", 1'b1);
    step();
    push(zero_e); check("flush_lu_bubble");
    flush = 1'b0;

    // Stall masks load-use and holds the load
    id_lw(); step();
    push(lw_e); check("lw_load3");
    stall_in = 1'b1; id_dep(); #1;
    chk_lu("stall_masks_lu", 1'b0);
    step();
    push(lw_e); check("stall_hold_lw");

    // Reset during hold clears on that edge
    reset = 1'b1; step();
    push(zero_e); check("reset_mid_hold");
    chk_lu("reset_mid_hold_lu", 1'b0);
    reset = 1'b0; stall_in = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
